// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// slot phase encoding and a constant log2 helper for counter widths.
package display_scan_ctrl_pkg;

    localparam logic [1:0] PH_BLANK = 2'd0;
    localparam logic [1:0] PH_ON    = 2'd1;
    localparam logic [1:0] PH_OFF   = 2'd2;

    typedef enum logic [1:0] {
        ST_BLANK = PH_BLANK,
        ST_ON    = PH_ON,
        ST_OFF   = PH_OFF
    } phase_e;

    function automatic int clog2(input int value);
        int result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit/control inputs from the datapath and the scanned outputs toward the
// decoder and the digit-enable pins.
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [3:0]              brightness;
    logic                    lzb_en;
    logic                    disp_en;
    logic [3:0]              digit_code;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_start;

    modport master (
        output digits, brightness, lzb_en, disp_en,
        input  digit_code, digit_sel, frame_start
    );

    modport slave (
        input  digits, brightness, lzb_en, disp_en,
        output digit_code, digit_sel, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timing: cycle-within-slot and slot-within-frame counters, plus the
// values they take on the next cycle so the controller can register outputs.
module display_scan_ctrl_scan_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    localparam int CW = clog2(SCAN_DIV),
    localparam int SW = clog2(NUM_DIGITS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic [CW-1:0] cyc_o,
    output logic [CW-1:0] cyc_nxt_o,
    output logic [SW-1:0] slot_nxt_o,
    output logic          slot_end_o,
    output logic          frame_end_o
);

    logic [CW-1:0] cyc_q;
    logic [SW-1:0] slot_q;
    logic          run_q;
    logic          slot_end;
    logic          frame_end;
    logic [CW-1:0] cyc_d;
    logic [SW-1:0] slot_d;

    assign slot_end  = run_q && (cyc_q == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (slot_q == SW'(NUM_DIGITS - 1));

    // The first cycle out of reset holds at t=0 so the registered outputs
    // line up with the counters from then on.
    always_comb begin
        cyc_d  = cyc_q;
        slot_d = slot_q;
        if (!run_q) begin
            cyc_d  = '0;
            slot_d = '0;
        end else if (frame_end) begin
            cyc_d  = '0;
            slot_d = '0;
        end else if (slot_end) begin
            cyc_d  = '0;
            slot_d = slot_q + SW'(1);
        end else begin
            cyc_d  = cyc_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cyc_q  <= '0;
            slot_q <= '0;
            run_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            slot_q <= slot_d;
            run_q  <= 1'b1;
        end
    end

    assign cyc_o       = cyc_q;
    assign cyc_nxt_o   = cyc_d;
    assign slot_nxt_o  = slot_d;
    assign slot_end_o  = slot_end;
    assign frame_end_o = frame_end;

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS digits through one shared 7-segment decoder with per-slot
// blanking, PWM brightness, optional leading-zero blanking and frame snapshots.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    display_scan_ctrl_if.slave  bus
);

    localparam int CW = clog2(SCAN_DIV);
    localparam int SW = clog2(NUM_DIGITS);
    localparam int S  = (SCAN_DIV - BLANK_CYCLES) / 16;

    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_nxt;
    logic [SW-1:0] slot_nxt;
    logic          slot_end;
    logic          frame_end;

    display_scan_ctrl_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_timer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cyc_o       (cyc_q),
        .cyc_nxt_o   (cyc_nxt),
        .slot_nxt_o  (slot_nxt),
        .slot_end_o  (slot_end),
        .frame_end_o (frame_end)
    );

    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [3:0]              snap_bright_q, snap_bright_d;
    logic                    snap_lzb_q, snap_lzb_d;
    logic                    snap_en_q, snap_en_d;

    // The next-cycle outputs read the _d snapshot so the first cycle of a
    // frame already shows the freshly latched values.
    always_comb begin
        snap_digits_d = snap_digits_q;
        snap_bright_d = snap_bright_q;
        snap_lzb_d    = snap_lzb_q;
        snap_en_d     = snap_en_q;
        if (reset_i || frame_end) begin
            snap_digits_d = bus.digits;
            snap_bright_d = bus.brightness;
            snap_lzb_d    = bus.lzb_en;
            snap_en_d     = bus.disp_en;
        end
    end

    always_ff @(posedge clk_i) begin
        snap_digits_q <= snap_digits_d;
        snap_bright_q <= snap_bright_d;
        snap_lzb_q    <= snap_lzb_d;
        snap_en_q     <= snap_en_d;
    end

    function automatic logic suppressed(input logic [4*NUM_DIGITS-1:0] d,
                                        input logic [SW-1:0] slot,
                                        input logic lzb,
                                        input logic en);
        logic upper_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(slot) && d[4*i +: 4] != 4'h0) upper_nonzero = 1'b1;
        end
        return !en || (lzb && slot != '0 && !upper_nonzero);
    endfunction

    phase_e        phase_q, phase_d;
    logic [CW-1:0] on_last;

    assign on_last = CW'(BLANK_CYCLES - 1 + (int'(snap_bright_q) + 1) * S);

    always_ff @(posedge clk_i) begin
        if (reset_i) phase_q <= ST_BLANK;
        else         phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            ST_BLANK: if (cyc_q == CW'(BLANK_CYCLES - 1)) phase_d = ST_ON;
            ST_ON: begin
                if (slot_end)                                        phase_d = ST_BLANK;
                else if (snap_bright_q != 4'hF && cyc_q == on_last) phase_d = ST_OFF;
            end
            ST_OFF:   if (slot_end) phase_d = ST_BLANK;
            default:  phase_d = ST_BLANK;
        endcase
    end

    logic [3:0]            digit_code_q, digit_code_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  frame_start_q, frame_start_d;

    always_comb begin
        digit_code_d  = snap_digits_d[4*slot_nxt +: 4];
        digit_sel_d   = '0;
        frame_start_d = (slot_nxt == '0) && (cyc_nxt == '0);
        if (phase_d == ST_ON && !suppressed(snap_digits_d, slot_nxt, snap_lzb_d, snap_en_d)) begin
            digit_sel_d = NUM_DIGITS'(1) << slot_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            digit_code_q  <= '0;
            digit_sel_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            digit_code_q  <= digit_code_d;
            digit_sel_q   <= digit_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.digit_code  = digit_code_q;
    assign bus.digit_sel   = digit_sel_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a timeline model predicts each
// cycle's outputs, a monitor compares them after every clock edge.
module tb_display_scan_ctrl;

    localparam int ND    = 4;
    localparam int SD    = 36;
    localparam int BC    = 4;
    localparam int S     = (SD - BC) / 16;
    localparam int FRAME = SD * ND;

    typedef struct packed {
        int              t;
        logic [3:0]      code;
        logic [ND-1:0]   sel;
        logic            fs;
    } exp_t;

    logic clk;
    logic rst;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int          m_next_t = 0;
    logic [15:0] m_dig;
    logic [3:0]  m_br;
    logic        m_lzb;
    logic        m_en;

    function automatic exp_t model(input int t);
        exp_t e;
        int cyc, slot, upper;
        logic lit;
        cyc   = t % SD;
        slot  = (t / SD) % ND;
        upper = int'(m_dig) >> (4 * slot);
        lit   = (cyc >= BC) && (cyc < BC + (int'(m_br) + 1) * S);
        e.t    = t;
        e.code = m_dig[4*slot +: 4];
        e.fs   = (t % FRAME) == 0;
        e.sel  = '0;
        if (lit && m_en && !(m_lzb && slot > 0 && upper == 0)) e.sel = ND'(1 << slot);
        return e;
    endfunction

    task automatic take_snapshot();
        m_dig = bus.digits;
        m_br  = bus.brightness;
        m_lzb = bus.lzb_en;
        m_en  = bus.disp_en;
    endtask

    // Predict the outputs after the coming edge, then move to the next negedge.
    task automatic step();
        exp_t e;
        if (rst) begin
            take_snapshot();
            e = '{t: -1, code: 4'h0, sel: '0, fs: 1'b0};
            m_next_t = 0;
        end else begin
            if (m_next_t != 0 && (m_next_t % FRAME) == 0) take_snapshot();
            e = model(m_next_t);
            m_next_t++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < FRAME && (m_next_t % FRAME) != pos; k++) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.digit_code === e.code && bus.digit_sel === e.sel && bus.frame_start === e.fs)
                    n_pass++;
                else
                    $display("FAIL out t=%0d: got code=%h sel=%b fs=%b, want code=%h sel=%b fs=%b",
                             e.t, bus.digit_code, bus.digit_sel, bus.frame_start,
                             e.code, e.sel, e.fs);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst            = 1'b1;
        bus.digits     = 16'h4321;
        bus.brightness = 4'hF;
        bus.lzb_en     = 1'b0;
        bus.disp_en    = 1'b1;
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        bus.brightness = 4'h0;
        run(FRAME);
        bus.brightness = 4'h7;
        run(FRAME);

        bus.brightness = 4'hF;
        bus.lzb_en     = 1'b1;
        bus.digits     = 16'h0070;
        run(FRAME);
        bus.digits = 16'h0000;
        run(FRAME);
        bus.digits = 16'h1000;
        run(FRAME);

        bus.lzb_en = 1'b0;
        bus.digits = 16'h1111;
        run_to(0);
        run_to(50);
        bus.digits = 16'h2222;
        run(FRAME);

        bus.disp_en = 1'b0;
        run_to(0);
        run(1);
        bus.disp_en = 1'b1;
        run(FRAME);

        run_to(60);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(FRAME + 10);

        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                for (int i = 0; i < ND; i++)
                    bus.digits[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                bus.brightness = 4'($urandom_range(0, 15));
                bus.lzb_en     = 1'($urandom_range(0, 1));
                bus.disp_en    = ($urandom_range(0, 5) != 0);
            end
            rst = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0;
        run(2);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
